// File: rtl/serial_cmd_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : serial_cmd_pkg                                                |
// | Purpose  : Shared types and ASCII constants for the serial command       |
// |            decoder (parser state encoding, command/terminator bytes).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package serial_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GOT_L  = 3'd1,
      S_GOT_HI = 3'd2,
      S_GOT_LO = 3'd3,
      S_GOT_C  = 3'd4,
      S_ERROR  = 3'd5,
      S_REPLY  = 3'd6
   } state_t;

   localparam logic [7:0] CH_L  = 8'h4C;  // 'L'
   localparam logic [7:0] CH_C  = 8'h43;  // 'C'
   localparam logic [7:0] CH_CR = 8'h0D;  // carriage return
   localparam logic [7:0] CH_LF = 8'h0A;  // line feed

   // Either line ending closes a command.
   function automatic logic is_term(input logic [7:0] b);
      return (b == CH_CR) || (b == CH_LF);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_cmd_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : serial_cmd_decoder_if                                        |
// | Purpose   : Byte-level rx/tx handshake between the AVR serial interface  |
// |             (master) and the command decoder (slave).                    |
// | Signals   : rx_data/new_rx_data  received byte + one-cycle strobe        |
// |             tx_data/new_tx_data  reply byte + one-cycle send request     |
// |             tx_busy              transmitter cannot accept a byte        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface serial_cmd_decoder_if;
   import serial_cmd_pkg::*;

   logic [7:0] rx_data;
   logic       new_rx_data;
   logic [7:0] tx_data;
   logic       new_tx_data;
   logic       tx_busy;

   modport master (
      output rx_data, new_rx_data, tx_busy,
      input  tx_data, new_tx_data
   );

   modport slave (
      input  rx_data, new_rx_data, tx_busy,
      output tx_data, new_tx_data
   );

endinterface
`default_nettype wire

// File: rtl/serial_cmd_decoder_hex_ascii_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hex_ascii_decode                                              |
// | Purpose  : Combinational ASCII hex digit decoder (0-9, A-F, a-f).        |
// | Ports    : data_in [7:0]  byte to classify                               |
// |            is_hex         1 when data_in is a hex digit                  |
// |            nibble [3:0]   digit value (0 when not a hex digit)           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hex_ascii_decode
   import serial_cmd_pkg::*;
(
   input  wire  [7:0] data_in,
   output logic       is_hex,
   output logic [3:0] nibble
);

   always_comb begin
      is_hex = 1'b0;
      nibble = 4'h0;
      if ((data_in >= 8'h30) && (data_in <= 8'h39)) begin
         is_hex = 1'b1;
         nibble = data_in[3:0];
      end else if (((data_in >= 8'h41) && (data_in <= 8'h46)) ||
                   ((data_in >= 8'h61) && (data_in <= 8'h66))) begin
         // Letters A-F/a-f have low nibble 1..6; adding 9 maps them to A..F.
         is_hex = 1'b1;
         nibble = data_in[3:0] + 4'd9;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_cmd_decoder                                            |
// | Purpose  : Parses ASCII line commands from the serial rx stream, drives  |
// |            an 8-bit LED register and answers each command with a single  |
// |            ACK/NAK byte on the tx handshake.                             |
// |              "L<hex><hex><term>" -> load LEDs, ACK                       |
// |              "C<term>"           -> clear LEDs, ACK                      |
// |              "<term>"            -> ignored                              |
// |              anything else       -> NAK                                  |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            bus       serial_cmd_decoder_if.slave (rx/tx handshake)       |
// |            led_value LED register                                        |
// |            cmd_valid pulse when led_value is updated                     |
// |            cmd_error pulse on NAK or timeout abort                       |
// |            rx_drop   pulse when a byte arrives while a reply is pending  |
// | Config   : `define CMD_TIMEOUT_EN enables discarding a partial command   |
// |            after TIMEOUT_CYCLES idle cycles.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module serial_cmd_decoder
   import serial_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter logic [7:0]  ACK_CHAR       = 8'h4B,
   parameter logic [7:0]  NAK_CHAR       = 8'h3F
) (
   input  wire                        clk,
   input  wire                        rst_n,
   serial_cmd_decoder_if.slave        bus,
   output logic [7:0]                 led_value,
   output logic                       cmd_valid,
   output logic                       cmd_error,
   output logic                       rx_drop
);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_led, w_led_nxt;
   logic [7:0] r_pend, w_pend_nxt;     // LED byte being assembled from two digits
   logic [7:0] r_tx_data, w_tx_data_nxt;
   logic       r_cmd_valid, w_cmd_valid_nxt;
   logic       r_cmd_error, w_cmd_error_nxt;
   logic       r_rx_drop, w_rx_drop_nxt;
   logic       w_new_tx;
   logic       w_is_hex;
   logic [3:0] w_nibble;
   logic       w_is_term;
   logic       w_timeout;

   hex_ascii_decode u_hex (
      .data_in (bus.rx_data),
      .is_hex  (w_is_hex),
      .nibble  (w_nibble)
   );

   assign w_is_term = is_term(bus.rx_data);

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_idle_cnt;
   logic             w_in_cmd;

   assign w_in_cmd  = (r_state != S_IDLE) && (r_state != S_REPLY);
   // A byte arriving on the expiry cycle takes precedence over the abort.
   assign w_timeout = w_in_cmd && !bus.new_rx_data && (r_idle_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n || bus.new_rx_data || !w_in_cmd || w_timeout) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_led       <= 8'h00;
         r_pend      <= 8'h00;
         r_tx_data   <= 8'h00;
         r_cmd_valid <= 1'b0;
         r_cmd_error <= 1'b0;
         r_rx_drop   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_led       <= w_led_nxt;
         r_pend      <= w_pend_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_cmd_valid <= w_cmd_valid_nxt;
         r_cmd_error <= w_cmd_error_nxt;
         r_rx_drop   <= w_rx_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_led_nxt       = r_led;
      w_pend_nxt      = r_pend;
      w_tx_data_nxt   = r_tx_data;
      w_cmd_valid_nxt = 1'b0;
      w_cmd_error_nxt = 1'b0;
      w_rx_drop_nxt   = 1'b0;
      w_new_tx        = 1'b0;

      if (r_state == S_REPLY) begin
         // Bytes cannot be queued behind a pending reply; they are discarded.
         w_rx_drop_nxt = bus.new_rx_data;
         if (!bus.tx_busy && rst_n) begin
            w_new_tx    = 1'b1;
            w_state_nxt = S_IDLE;
         end
      end else if (bus.new_rx_data) begin
         case (r_state)
            S_IDLE: begin
               if (bus.rx_data == CH_L)      w_state_nxt = S_GOT_L;
               else if (bus.rx_data == CH_C) w_state_nxt = S_GOT_C;
               else if (w_is_term)           w_state_nxt = S_IDLE;
               else                          w_state_nxt = S_ERROR;
            end
            S_GOT_L, S_GOT_HI: begin
               if (w_is_hex) begin
                  if (r_state == S_GOT_L) begin
                     w_pend_nxt[7:4] = w_nibble;
                     w_state_nxt     = S_GOT_HI;
                  end else begin
                     w_pend_nxt[3:0] = w_nibble;
                     w_state_nxt     = S_GOT_LO;
                  end
               end else if (w_is_term) begin
                  w_tx_data_nxt   = NAK_CHAR;
                  w_cmd_error_nxt = 1'b1;
                  w_state_nxt     = S_REPLY;
               end else begin
                  w_state_nxt = S_ERROR;
               end
            end
            S_GOT_LO, S_GOT_C: begin
               if (w_is_term) begin
                  w_led_nxt       = (r_state == S_GOT_LO) ? r_pend : 8'h00;
                  w_tx_data_nxt   = ACK_CHAR;
                  w_cmd_valid_nxt = 1'b1;
                  w_state_nxt     = S_REPLY;
               end else begin
                  w_state_nxt = S_ERROR;
               end
            end
            S_ERROR: begin
               if (w_is_term) begin
                  w_tx_data_nxt   = NAK_CHAR;
                  w_cmd_error_nxt = 1'b1;
                  w_state_nxt     = S_REPLY;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_cmd_error_nxt = 1'b1;
         w_state_nxt     = S_IDLE;
      end
   end

   assign led_value       = r_led;
   assign cmd_valid       = r_cmd_valid;
   assign cmd_error       = r_cmd_error;
   assign rx_drop         = r_rx_drop;
   assign bus.tx_data     = r_tx_data;
   assign bus.new_tx_data = w_new_tx;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_cmd_decoder                                         |
// | Purpose  : Self-checking bench for serial_cmd_decoder. Stimulus pushes   |
// |            expected output events into a scoreboard queue; a monitor     |
// |            pops and compares whenever the DUT pulses an output.          |
// | Config   : honours `define CMD_TIMEOUT_EN (TIMEOUT_CYCLES = 16).         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serial_cmd_decoder;

   typedef enum int {EV_VALID, EV_ERROR, EV_DROP, EV_TX} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] value;   // led_value for pulses, tx_data for EV_TX
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] led_value;
   logic       cmd_valid;
   logic       cmd_error;
   logic       rx_drop;

   ev_t sb[$];
   int  errors = 0;
   int  checks = 0;

   serial_cmd_decoder_if bus ();

   serial_cmd_decoder #(
      .TIMEOUT_CYCLES (16),
      .ACK_CHAR       (8'h4B),
      .NAK_CHAR       (8'h3F)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .led_value (led_value),
      .cmd_valid (cmd_valid),
      .cmd_error (cmd_error),
      .rx_drop   (rx_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string kname(input ev_kind_t k);
      case (k)
         EV_VALID: return "cmd_valid";
         EV_ERROR: return "cmd_error";
         EV_DROP:  return "rx_drop";
         default:  return "tx";
      endcase
   endfunction

   task automatic check_ev(input ev_kind_t k, input logic [7:0] v);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got value %02h, nothing expected", kname(k), v);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.value != v) begin
            errors++;
            $display("FAIL event_order: got %s value %02h, required %s value %02h",
                     kname(k), v, kname(e.kind), e.value);
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid) check_ev(EV_VALID, led_value);
         if (cmd_error) check_ev(EV_ERROR, led_value);
         if (rx_drop)   check_ev(EV_DROP, led_value);
         if (bus.new_tx_data) begin
            checks++;
            if (bus.tx_busy) begin
               errors++;
               $display("FAIL tx_while_busy: new_tx_data=1 with tx_busy=1, required 0");
            end
            check_ev(EV_TX, bus.tx_data);
         end
      end
   end

   task automatic expect_ev(input ev_kind_t k, input logic [7:0] v);
      ev_t e;
      e.kind  = k;
      e.value = v;
      sb.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.rx_data     = b;
      bus.new_rx_data = 1'b1;
      @(posedge clk);
      #1;
      bus.new_rx_data = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h, required %02h", name, act, exp);
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: %0d events outstanding, required 0", tag, sb.size());
         sb.delete();
      end
      idle(4);   // window for any stray extra pulse to reach the monitor
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      bus.rx_data     = 8'h00;
      bus.new_rx_data = 1'b0;
      bus.tx_busy     = 1'b0;
      idle(3);
      rst_n = 1'b1;

      // Reset state
      check_val("rst_led_value",   led_value, 8'h00);
      check_val("rst_tx_data",     bus.tx_data, 8'h00);
      check_val("rst_new_tx_data", {7'd0, bus.new_tx_data}, 8'h00);
      check_val("rst_pulses",      {5'd0, cmd_valid, cmd_error, rx_drop}, 8'h00);

      // "L3A\r" -> 3A, ACK
      expect_ev(EV_VALID, 8'h3A);
      expect_ev(EV_TX,    8'h4B);
      send_byte("L"); send_byte("3"); send_byte("A"); send_byte(8'h0D);
      drain("load_3a", 20);
      check_val("led_after_L3A", led_value, 8'h3A);
      check_val("tx_data_hold",  bus.tx_data, 8'h4B);

      // "Lz1\n" -> NAK, LEDs unchanged
      expect_ev(EV_ERROR, 8'h3A);
      expect_ev(EV_TX,    8'h3F);
      send_byte("L"); send_byte("z"); send_byte("1"); send_byte(8'h0A);
      drain("bad_digit", 20);
      check_val("led_after_Lz1", led_value, 8'h3A);

      // "C\r" -> clear, ACK
      expect_ev(EV_VALID, 8'h00);
      expect_ev(EV_TX,    8'h4B);
      send_byte("C"); send_byte(8'h0D);
      drain("clear", 20);
      check_val("led_after_C", led_value, 8'h00);

      // lone terminator: nothing at all
      send_byte(8'h0D);
      idle(10);
      check_val("led_after_lone_cr", led_value, 8'h00);
      check_val("tx_data_after_lone_cr", bus.tx_data, 8'h4B);

      // lowercase hex digits
      expect_ev(EV_VALID, 8'hAB);
      expect_ev(EV_TX,    8'h4B);
      send_byte("L"); send_byte("a"); send_byte("b"); send_byte(8'h0A);
      drain("lowercase", 20);

      // terminator straight after 'L' -> NAK
      expect_ev(EV_ERROR, 8'hAB);
      expect_ev(EV_TX,    8'h3F);
      send_byte("L"); send_byte(8'h0D);
      drain("short_L", 20);

      // extra digit -> ERROR absorbs it, NAK on terminator
      expect_ev(EV_ERROR, 8'hAB);
      expect_ev(EV_TX,    8'h3F);
      send_byte("L"); send_byte("3"); send_byte("A"); send_byte("5"); send_byte(8'h0D);
      drain("extra_digit", 20);
      check_val("led_after_extra", led_value, 8'hAB);

      // "Lff\r" with transmitter busy; byte during REPLY is dropped
      bus.tx_busy = 1'b1;
      expect_ev(EV_VALID, 8'hFF);
      send_byte("L"); send_byte("f"); send_byte("f"); send_byte(8'h0D);
      idle(2);
      check_val("led_while_busy", led_value, 8'hFF);
      expect_ev(EV_DROP, 8'hFF);
      send_byte("X");
      idle(90);
      check_val("pending_while_busy", {7'd0, bus.new_tx_data}, 8'h00);
      expect_ev(EV_TX, 8'h4B);
      bus.tx_busy = 1'b0;
      drain("busy", 20);
      check_val("led_after_busy", led_value, 8'hFF);

`ifdef CMD_TIMEOUT_EN
      // partial command times out silently (error pulse only)
      expect_ev(EV_ERROR, 8'hFF);
      send_byte("L"); send_byte("3");
      idle(20);
      drain("timeout", 10);
      expect_ev(EV_VALID, 8'h05);
      expect_ev(EV_TX,    8'h4B);
      send_byte("L"); send_byte("0"); send_byte("5"); send_byte(8'h0D);
      drain("after_timeout", 20);
      check_val("led_after_timeout", led_value, 8'h05);
`else
      // partial command persists, so "L3" + "L05\r" is one malformed command
      expect_ev(EV_ERROR, 8'hFF);
      expect_ev(EV_TX,    8'h3F);
      send_byte("L"); send_byte("3");
      idle(20);
      send_byte("L"); send_byte("0"); send_byte("5"); send_byte(8'h0D);
      drain("no_timeout", 20);
      check_val("led_no_timeout", led_value, 8'hFF);
`endif

      // reset mid-command: "A\r" afterwards is parsed from IDLE -> NAK
      send_byte("L"); send_byte("3");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_val("led_after_midreset", led_value, 8'h00);
      expect_ev(EV_ERROR, 8'h00);
      expect_ev(EV_TX,    8'h3F);
      send_byte("A"); send_byte(8'h0D);
      drain("midreset", 20);
      check_val("led_final", led_value, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
